// File: rtl/config_loader.sv
// Bitstream loader for the tile configuration bus: unpacks a {magic,count} header
// plus count (addr,data) word pairs into single-cycle config write strobes.
module config_loader #(
    parameter logic [15:0] MAGIC     = 16'hCF60,
    parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_valid,
    output logic        done,
    output logic        error,
    output logic [15:0] writes_issued
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        DATA,
        EMIT,
        DONE,
        ERR
    } state_t;

    typedef struct packed {
        logic [15:0] magic;
        logic [15:0] count;
    } hdr_t;

    state_t      state;
    logic [15:0] remaining;
    logic [31:0] addr_reg;
    logic        accept;
    hdr_t        hdr;

    assign accept = in_valid & in_ready;
    assign hdr    = hdr_t'(in_data);

    // in_ready is loaded together with the next state so it is a pure state decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            config_valid  <= 1'b0;
            config_addr   <= IDLE_ADDR;
            config_data   <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            writes_issued <= '0;
            remaining     <= '0;
            addr_reg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= HDR;
                        in_ready <= 1'b1;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (hdr.magic != MAGIC) begin
                            state    <= ERR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (hdr.count == 16'd0) begin
                            state         <= DONE;
                            done          <= 1'b1;
                            writes_issued <= '0;
                            in_ready      <= 1'b0;
                        end else begin
                            state         <= ADDR;
                            remaining     <= hdr.count;
                            writes_issued <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (accept) begin
                        addr_reg <= in_data;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    // Strobe is presented straight from the data-word edge: one cycle latency.
                    if (accept) begin
                        config_data  <= in_data;
                        config_addr  <= addr_reg;
                        config_valid <= 1'b1;
                        in_ready     <= 1'b0;
                        state        <= EMIT;
                    end
                end
                EMIT: begin
                    config_valid  <= 1'b0;
                    config_addr   <= IDLE_ADDR;
                    writes_issued <= writes_issued + 16'd1;
                    remaining     <= remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= ADDR;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state         <= HDR;
                        done          <= 1'b0;
                        writes_issued <= '0;
                        in_ready      <= 1'b1;
                    end
                end
                ERR: begin
                    if (start) begin
                        state    <= HDR;
                        error    <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    in_ready     <= 1'b0;
                    config_valid <= 1'b0;
                    config_addr  <= IDLE_ADDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: per-cycle vector table plus hand-written
// sequences for stalls, async reset and ignored start pulses.
module tb_config_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_valid;
    logic        done;
    logic        error;
    logic [15:0] writes_issued;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    config_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_valid (config_valid),
        .done         (done),
        .error        (error),
        .writes_issued(writes_issued)
    );

    typedef struct packed {
        logic        st;
        logic        iv;
        logic [31:0] d;
        logic        rdy;
        logic        cv;
        logic [31:0] a;
        logic [31:0] cd;
        logic        dn;
        logic        er;
        logic [15:0] wi;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    localparam logic [31:0] F = 32'hFFFF_FFFF;
    localparam logic [83:0] RST_OUTS = {1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 16'h0};

    vec_t vt[$];
    wr_t  exp_q[$];
    bit   mon_en = 1'b0;
    bit   is_data = 1'b0;
    bit   cv_prev = 1'b0;
    bit   dhs_prev = 1'b0;
    int   n_strobe = 0;

    function automatic logic [83:0] outs();
        return {in_ready, config_valid, config_addr, config_data, done, error, writes_issued};
    endfunction

    task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Strobe monitor: order, payload, one-cycle latency and no back-to-back strobes.
    always @(negedge clk) begin
        if (mon_en) begin
            if (config_valid) begin
                wr_t w;
                n_strobe++;
                chk("no_back_to_back", {83'd0, cv_prev}, 84'd0);
                chk("strobe_latency", {83'd0, dhs_prev}, 84'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {52'd0, config_addr}, 84'd0);
                end else begin
                    w = exp_q.pop_front();
                    chk("strobe_payload", {20'd0, config_addr, config_data}, {20'd0, w.a, w.d});
                end
            end
            cv_prev  = config_valid;
            dhs_prev = in_valid && in_ready && is_data;
        end
    end

    task automatic send(input logic [31:0] w, input bit isd, input bit gaps, input bit st);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            start = st;
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = w;
                is_data  = isd;
            end
            @(negedge clk);
            got = in_valid && in_ready;
            n++;
        end
        if (!got) chk("send_timeout", 84'd0, 84'd1);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", {83'd0, done}, 84'd1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic stream(input int n, input logic [15:0] base, input bit gaps, input bit st);
        int s0;
        logic [15:0] cnt;
        s0  = n_strobe;
        cnt = 16'(n);
        pulse_start();
        for (int i = 0; i < n; i++)
            exp_q.push_back({16'h0007, base + 16'(i), 32'h1000_0000 + 32'(base) * 32'd16 + 32'(i)});
        send({16'hCF60, cnt}, 1'b0, gaps, st);
        for (int i = 0; i < n; i++) begin
            send({16'h0007, base + 16'(i)}, 1'b0, gaps, st);
            send(32'h1000_0000 + 32'(base) * 32'd16 + 32'(i), 1'b1, gaps, st);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        is_data  = 1'b0;
        start    = 1'b0;
        wait_done(200);
        chk("writes_issued", {68'd0, writes_issued}, {68'd0, cnt});
        chk("strobe_count", 84'(n_strobe - s0), 84'(n));
        chk("queue_drained", 84'(exp_q.size()), 84'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        //            st iv d               rdy cv a             cd     dn er wi
        vt.push_back({1'b1, 1'b1, 32'hCF60_0002, 1'b0, 1'b0, F, 32'h0, 1'b0, 1'b0, 16'd0});
        vt.push_back({1'b0, 1'b1, 32'hCF60_0002, 1'b1, 1'b0, F, 32'h0, 1'b0, 1'b0, 16'd0});
        vt.push_back({1'b0, 1'b1, 32'h0007_0003, 1'b1, 1'b0, F, 32'h0, 1'b0, 1'b0, 16'd0});
        vt.push_back({1'b0, 1'b1, 32'h0000_0005, 1'b1, 1'b0, F, 32'h0, 1'b0, 1'b0, 16'd0});
        vt.push_back({1'b0, 1'b1, 32'h0007_0004, 1'b0, 1'b1, 32'h0007_0003, 32'h5, 1'b0, 1'b0, 16'd0});
        vt.push_back({1'b0, 1'b1, 32'h0007_0004, 1'b1, 1'b0, F, 32'h5, 1'b0, 1'b0, 16'd1});
        vt.push_back({1'b0, 1'b1, 32'h0000_000A, 1'b1, 1'b0, F, 32'h5, 1'b0, 1'b0, 16'd1});
        vt.push_back({1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0007_0004, 32'hA, 1'b0, 1'b0, 16'd1});
        vt.push_back({1'b0, 1'b0, 32'h0,         1'b0, 1'b0, F, 32'hA, 1'b1, 1'b0, 16'd2});
        // bad magic, then recovery
        vt.push_back({1'b1, 1'b0, 32'h0,         1'b0, 1'b0, F, 32'hA, 1'b1, 1'b0, 16'd2});
        vt.push_back({1'b0, 1'b1, 32'hBEEF_0001, 1'b1, 1'b0, F, 32'hA, 1'b0, 1'b0, 16'd0});
        vt.push_back({1'b0, 1'b1, 32'h0007_0001, 1'b0, 1'b0, F, 32'hA, 1'b0, 1'b1, 16'd0});
        vt.push_back({1'b1, 1'b0, 32'h0,         1'b0, 1'b0, F, 32'hA, 1'b0, 1'b1, 16'd0});
        vt.push_back({1'b0, 1'b1, 32'hCF60_0001, 1'b1, 1'b0, F, 32'hA, 1'b0, 1'b0, 16'd0});
        vt.push_back({1'b0, 1'b1, 32'h0007_0009, 1'b1, 1'b0, F, 32'hA, 1'b0, 1'b0, 16'd0});
        vt.push_back({1'b0, 1'b1, 32'h0000_0077, 1'b1, 1'b0, F, 32'hA, 1'b0, 1'b0, 16'd0});
        vt.push_back({1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0007_0009, 32'h77, 1'b0, 1'b0, 16'd0});
        vt.push_back({1'b0, 1'b0, 32'h0,         1'b0, 1'b0, F, 32'h77, 1'b1, 1'b0, 16'd1});
        // zero-count header
        vt.push_back({1'b1, 1'b0, 32'h0,         1'b0, 1'b0, F, 32'h77, 1'b1, 1'b0, 16'd1});
        vt.push_back({1'b0, 1'b1, 32'hCF60_0000, 1'b1, 1'b0, F, 32'h77, 1'b0, 1'b0, 16'd0});
        vt.push_back({1'b0, 1'b0, 32'h0,         1'b0, 1'b0, F, 32'h77, 1'b1, 1'b0, 16'd0});

        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        #12;
        chk("reset_state", outs(), RST_OUTS);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk); #1;
            start    = vt[i].st;
            in_valid = vt[i].iv;
            in_data  = vt[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(),
                {vt[i].rdy, vt[i].cv, vt[i].a, vt[i].cd, vt[i].dn, vt[i].er, vt[i].wi});
        end
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b0;

        mon_en = 1'b1;
        stream(4, 16'h0010, 1'b1, 1'b0);
        stream(2, 16'h0030, 1'b0, 1'b1);

        // async reset between addr and data words of the second write
        pulse_start();
        exp_q.push_back({32'h0007_0020, 32'hC0DE_0001});
        send(32'hCF60_0003, 1'b0, 1'b0, 1'b0);
        send(32'h0007_0020, 1'b0, 1'b0, 1'b0);
        send(32'hC0DE_0001, 1'b1, 1'b0, 1'b0);
        send(32'h0007_0021, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0; is_data = 1'b0;
        #3 reset = 1'b0;
        #1 chk("async_reset_outs", outs(), RST_OUTS);
        chk("reset_queue_drained", 84'(exp_q.size()), 84'd0);
        s0 = n_strobe;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0BAD;
        repeat (8) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("no_strobe_after_reset", 84'(n_strobe - s0), 84'd0);
        chk("idle_after_reset", outs(), RST_OUTS);
        stream(1, 16'h0040, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
